mano_io_ctrl: RTL and testbench
===============================

MANO_IO_CTRL -- requirements
Module: mano_io_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of every INPR/OUTR channel register and CPU data bus.
REQ-002 Parameter N_CH, default 2, legal range 1..8: number of independent I/O channels; CH_W = max(1, clog2(N_CH)).
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port clr  in  1  reset, asynchronous, active-low.
REQ-005 Port dev_in_data  in  N_CH*DATA_W  device input bytes; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-006 Port dev_in_valid  in  N_CH; dev_in_ready  out  N_CH: per-channel device-to-INPR handshake.
REQ-007 Port dev_out_data  out  N_CH*DATA_W  OUTR contents, packed as dev_in_data.
REQ-008 Port dev_out_valid  out  N_CH; dev_out_ready  in  N_CH: per-channel OUTR-to-device handshake.
REQ-009 Port cpu_sel  in  CH_W  channel addressed by the CPU command.
REQ-010 Ports cpu_inp, cpu_out, cpu_ion, cpu_iof, int_ack  in  1 each: CPU command strobes, one cycle each.
REQ-011 Port cpu_wdata  in  DATA_W  AC value for OUT; cpu_rdata  out  DATA_W  INPR value returned by INP.
REQ-012 Ports ski, sko  out  1  skip conditions: FGI and FGO of the selected channel.
REQ-013 Ports ien  out  1; irq  out  1 (R flip-flop); irq_ch  out  CH_W  interrupting channel.
REQ-014 Ports ovr_err, cmd_err  out  1  one-cycle error pulses.

Function
REQ-015 Each channel SHALL hold INPR[k], FGI[k], OUTR[k] and FGO[k].
REQ-016 dev_in_ready[k] SHALL equal ~FGI[k]. On valid&ready, INPR[k] loads the data and FGI[k] sets at the same edge.
REQ-017 INP: cpu_rdata SHALL register INPR[cpu_sel] with 1-cycle latency, and FGI[cpu_sel] SHALL clear at the same edge.
REQ-018 INP with FGI[sel]=0: cpu_rdata SHALL return stale INPR. If a device write lands on that channel in the same cycle, the device write SHALL win and FGI SHALL set.
REQ-019 dev_out_valid[k] SHALL equal ~FGO[k]. On valid&ready, FGO[k] SHALL set.
REQ-020 OUT with FGO[sel]=1: OUTR[sel] SHALL load cpu_wdata and FGO[sel] SHALL clear.
REQ-021 OUT with FGO[sel]=0: the write SHALL be dropped and ovr_err SHALL pulse for 1 cycle.
REQ-022 ski and sko SHALL be combinational from cpu_sel.
REQ-023 ION SHALL set ien and IOF SHALL clear it.
REQ-024 R SHALL set at the edge where ien=1 and (|FGI | |FGO)=1. R SHALL hold until int_ack.
REQ-025 int_ack SHALL clear R and ien at the same edge. int_ack concurrent with ION: ien SHALL clear (ack wins).
REQ-026 irq_ch SHALL be the lowest k with FGI[k]|FGO[k], computed combinationally, and 0 when none.
REQ-027 More than one of cpu_inp/cpu_out/cpu_ion/cpu_iof in one cycle: none SHALL execute and cmd_err SHALL pulse. int_ack is exempt.
REQ-028 cpu_sel >= N_CH with any command: no state change; cmd_err SHALL pulse; ski and sko SHALL read 0.

Reset
REQ-029 While clr=0: INPR=0, OUTR=0, FGI=0, FGO=all ones, ien=0, R=0, cpu_rdata=0, ovr_err=0, cmd_err=0.
REQ-030 Reset asserted mid-handshake SHALL abort it. Device data presented during reset SHALL be lost. Outputs SHALL follow reset immediately, without waiting for a clock edge.

Structure
REQ-031 Shared package mano_pkg SHALL hold the DATA_W and N_CH defaults and the clog2-based CH_W function.
REQ-032 One sub-module mano_io_chan SHALL implement one channel: INPR, OUTR, FGI, FGO, both handshakes and the ovr detection. It SHALL be instantiated N_CH times by generate.
REQ-033 Command decode, the interrupt R/ien logic and the priority encoder SHALL reside in mano_io_ctrl.

Verification
REQ-034 Reset release with no stimulus: FGO=2'b11, dev_in_ready=2'b11, dev_out_valid=0, irq=0.
REQ-035 Device writes 8'd7 on ch1. Then INP with sel=1: cpu_rdata=8'd7 one cycle later, ski drops to 0, dev_in_ready[1] returns to 1.
REQ-036 OUT 8'hA5 on ch0: dev_out_valid[0]=1 and dev_out_data[7:0]=8'hA5. A second OUT 8'h3C before the device accepts: ovr_err pulses and OUTR stays 8'hA5. After dev_out_ready, FGO[0]=1.
REQ-037 ION, then device write on ch1 with ch0 idle after an OUT: irq=1 and irq_ch=1 next edge. int_ack gives irq=0 and ien=0. int_ack together with ION leaves ien=0.
REQ-038 cpu_inp and cpu_out in the same cycle: cmd_err=1, no flag changes. cpu_sel=2 with N_CH=2: cmd_err=1.
REQ-039 clr pulsed low while dev_out_valid[0]=1 and R=1: all outputs return to REQ-029 values asynchronously.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared defaults and width helper for the Mano-style I/O controller.
// Imported by the channel and the controller top.
package mano_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_CH_DEF   = 2;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mano_io_chan.sv
// One I/O channel: INPR/FGI input side, OUTR/FGO output side,
// device handshakes and OUT overrun detection.
module mano_io_chan
  import mano_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              inp,
  input  logic              out_cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] inpr,
  output logic              fgi,
  output logic              fgo,
  output logic              ovr
);

  assign in_ready  = ~fgi;
  assign out_valid = ~fgo;
  assign ovr       = out_cmd & ~fgo;

  // A device write takes priority over an INP clearing the flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      inpr     <= '0;
      fgi      <= 1'b0;
      out_data <= '0;
      fgo      <= 1'b1;
    end else begin
      if (in_valid && !fgi) begin
        inpr <= in_data;
        fgi  <= 1'b1;
      end else if (inp) begin
        fgi  <= 1'b0;
      end
      if (out_cmd && fgo) begin
        out_data <= wdata;
        fgo      <= 1'b0;
      end else if (!fgo && out_ready) begin
        fgo      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mano_io_ctrl.sv
// Multi-channel Mano I/O controller: command decode, interrupt
// enable / R flip-flop and lowest-channel interrupt priority.
module mano_io_ctrl
  import mano_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_CH   = N_CH_DEF,
  localparam int CH_W  = ch_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [N_CH*DATA_W-1:0]   dev_in_data,
  input  logic [N_CH-1:0]          dev_in_valid,
  output logic [N_CH-1:0]          dev_in_ready,
  output logic [N_CH*DATA_W-1:0]   dev_out_data,
  output logic [N_CH-1:0]          dev_out_valid,
  input  logic [N_CH-1:0]          dev_out_ready,
  input  logic [CH_W-1:0]          cpu_sel,
  input  logic                     cpu_inp,
  input  logic                     cpu_out,
  input  logic                     cpu_ion,
  input  logic                     cpu_iof,
  input  logic                     int_ack,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     ski,
  output logic                     sko,
  output logic                     ien,
  output logic                     irq,
  output logic [CH_W-1:0]          irq_ch,
  output logic                     ovr_err,
  output logic                     cmd_err
);

  logic [DATA_W-1:0] inpr [N_CH];
  logic [N_CH-1:0]   fgi;
  logic [N_CH-1:0]   fgo;
  logic [N_CH-1:0]   ovr;
  logic [N_CH-1:0]   inp_v;
  logic [N_CH-1:0]   out_v;

  logic [2:0] n_cmd;
  logic       any_cmd;
  logic       multi;
  logic       sel_ok;
  logic       go;
  logic       inp_ok;
  logic       out_ok;
  logic       ion_ok;
  logic       iof_ok;

  logic              sel_fgi;
  logic              sel_fgo;
  logic [DATA_W-1:0] sel_inpr;

  assign n_cmd   = 3'(cpu_inp) + 3'(cpu_out)
                 + 3'(cpu_ion) + 3'(cpu_iof);
  assign any_cmd = n_cmd != 3'd0;
  assign multi   = n_cmd > 3'd1;
  assign sel_ok  = {1'b0, cpu_sel} < (CH_W+1)'(N_CH);
  assign go      = any_cmd & ~multi & sel_ok;
  assign inp_ok  = go & cpu_inp;
  assign out_ok  = go & cpu_out;
  assign ion_ok  = go & cpu_ion;
  assign iof_ok  = go & cpu_iof;

  always_comb begin
    sel_fgi  = 1'b0;
    sel_fgo  = 1'b0;
    sel_inpr = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cpu_sel == CH_W'(k)) begin
        sel_fgi  = fgi[k];
        sel_fgo  = fgo[k];
        sel_inpr = inpr[k];
      end
    end
  end

  assign ski = sel_fgi & sel_ok;
  assign sko = sel_fgo & sel_ok;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign inp_v[k] = inp_ok & (cpu_sel == CH_W'(k));
    assign out_v[k] = out_ok & (cpu_sel == CH_W'(k));

    mano_io_chan #(.DATA_W(DATA_W)) u_chan (
      .clk       (clk),
      .clr       (clr),
      .in_data   (dev_in_data[k*DATA_W +: DATA_W]),
      .in_valid  (dev_in_valid[k]),
      .in_ready  (dev_in_ready[k]),
      .out_data  (dev_out_data[k*DATA_W +: DATA_W]),
      .out_valid (dev_out_valid[k]),
      .out_ready (dev_out_ready[k]),
      .inp       (inp_v[k]),
      .out_cmd   (out_v[k]),
      .wdata     (cpu_wdata),
      .inpr      (inpr[k]),
      .fgi       (fgi[k]),
      .fgo       (fgo[k]),
      .ovr       (ovr[k])
    );
  end

  // Downward scan so the lowest pending channel wins.
  always_comb begin
    irq_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (fgi[k] | fgo[k]) irq_ch = CH_W'(k);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cpu_rdata <= '0;
      ien       <= 1'b0;
      irq       <= 1'b0;
      ovr_err   <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      ovr_err <= |ovr;
      cmd_err <= any_cmd & (multi | ~sel_ok);
      if (inp_ok) cpu_rdata <= sel_inpr;
      if (int_ack)     ien <= 1'b0;
      else if (ion_ok) ien <= 1'b1;
      else if (iof_ok) ien <= 1'b0;
      if (int_ack)
        irq <= 1'b0;
      else if (ien && (|fgi || |fgo))
        irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mano_io_ctrl.sv
// Directed bench for mano_io_ctrl: a 2-channel main instance plus a
// 3-channel instance that can address a nonexistent channel.
module tb_mano_io_ctrl;

  localparam int DW = 8;
  localparam int N  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            clr;
  logic [N*DW-1:0] dev_in_data;
  logic [N-1:0]    dev_in_valid;
  logic [N-1:0]    dev_in_ready;
  logic [N*DW-1:0] dev_out_data;
  logic [N-1:0]    dev_out_valid;
  logic [N-1:0]    dev_out_ready;
  logic            cpu_sel;
  logic            cpu_inp, cpu_out, cpu_ion, cpu_iof, int_ack;
  logic [DW-1:0]   cpu_wdata;
  logic [DW-1:0]   cpu_rdata;
  logic            ski, sko, ien, irq;
  logic            irq_ch;
  logic            ovr_err, cmd_err;

  logic [3*DW-1:0] dev_in_data3;
  logic [2:0]      dev_in_valid3;
  logic [2:0]      dev_in_ready3;
  logic [3*DW-1:0] dev_out_data3;
  logic [2:0]      dev_out_valid3;
  logic [2:0]      dev_out_ready3;
  logic [1:0]      sel3;
  logic            inp3, out3;
  logic [DW-1:0]   wdata3;
  logic [DW-1:0]   rdata3;
  logic            ski3, sko3, ien3, irq3;
  logic [1:0]      irq_ch3;
  logic            ovr3, cmd3;

  int checks = 0;
  int errors = 0;

  mano_io_ctrl #(.DATA_W(DW), .N_CH(N)) dut (
    .clk           (clk),
    .clr           (clr),
    .dev_in_data   (dev_in_data),
    .dev_in_valid  (dev_in_valid),
    .dev_in_ready  (dev_in_ready),
    .dev_out_data  (dev_out_data),
    .dev_out_valid (dev_out_valid),
    .dev_out_ready (dev_out_ready),
    .cpu_sel       (cpu_sel),
    .cpu_inp       (cpu_inp),
    .cpu_out       (cpu_out),
    .cpu_ion       (cpu_ion),
    .cpu_iof       (cpu_iof),
    .int_ack       (int_ack),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .ski           (ski),
    .sko           (sko),
    .ien           (ien),
    .irq           (irq),
    .irq_ch        (irq_ch),
    .ovr_err       (ovr_err),
    .cmd_err       (cmd_err)
  );

  mano_io_ctrl #(.DATA_W(DW), .N_CH(3)) dut3 (
    .clk           (clk),
    .clr           (clr),
    .dev_in_data   (dev_in_data3),
    .dev_in_valid  (dev_in_valid3),
    .dev_in_ready  (dev_in_ready3),
    .dev_out_data  (dev_out_data3),
    .dev_out_valid (dev_out_valid3),
    .dev_out_ready (dev_out_ready3),
    .cpu_sel       (sel3),
    .cpu_inp       (inp3),
    .cpu_out       (out3),
    .cpu_ion       (1'b0),
    .cpu_iof       (1'b0),
    .int_ack       (1'b0),
    .cpu_wdata     (wdata3),
    .cpu_rdata     (rdata3),
    .ski           (ski3),
    .sko           (sko3),
    .ien           (ien3),
    .irq           (irq3),
    .irq_ch        (irq_ch3),
    .ovr_err       (ovr3),
    .cmd_err       (cmd3)
  );

  task automatic idle();
    cpu_inp = 0; cpu_out = 0; cpu_ion = 0;
    cpu_iof = 0; int_ack = 0;
    dev_in_valid = '0; dev_out_ready = '0;
    inp3 = 0; out3 = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dev_in_ready !== 2'b11 || dev_out_valid !== 2'b00) begin
      errors++;
      $display("FAIL rst_hs: rdy=%b vld=%b want 11 00",
               dev_in_ready, dev_out_valid);
    end
    checks++;
    if (irq !== 0 || ien !== 0 || cpu_rdata !== 0) begin
      errors++;
      $display("FAIL rst_regs: irq=%b ien=%b rd=%h want 0 0 00",
               irq, ien, cpu_rdata);
    end
    clr = 1;
    @(negedge clk);
    cpu_sel = 0; #1;
    checks++;
    if (sko !== 1 || ski !== 0) begin
      errors++;
      $display("FAIL rel_ch0: sko=%b ski=%b want 1 0", sko, ski);
    end
    cpu_sel = 1; #1;
    checks++;
    if (sko !== 1 || dev_in_ready !== 2'b11 ||
        dev_out_valid !== 2'b00 || irq !== 0) begin
      errors++;
      $display("FAIL rel_ch1: sko=%b rdy=%b vld=%b irq=%b",
               sko, dev_in_ready, dev_out_valid, irq);
    end
  endtask

  task automatic test_inp();
    @(negedge clk);
    dev_in_data = {8'd7, 8'd0};
    dev_in_valid = 2'b10;
    @(negedge clk);
    idle();
    cpu_sel = 1; #1;
    checks++;
    if (dev_in_ready !== 2'b01 || ski !== 1) begin
      errors++;
      $display("FAIL dev_wr: rdy=%b ski=%b want 01 1",
               dev_in_ready, ski);
    end
    cpu_inp = 1;
    @(negedge clk);
    idle();
    checks++;
    if (cpu_rdata !== 8'd7 || ski !== 0 || dev_in_ready !== 2'b11) begin
      errors++;
      $display("FAIL inp: rd=%h ski=%b rdy=%b want 07 0 11",
               cpu_rdata, ski, dev_in_ready);
    end
    cpu_inp = 1;
    dev_in_data = {8'd9, 8'd0};
    dev_in_valid = 2'b10;
    @(negedge clk);
    idle();
    checks++;
    if (cpu_rdata !== 8'd7 || ski !== 1) begin
      errors++;
      $display("FAIL inp_race: rd=%h ski=%b want 07 1",
               cpu_rdata, ski);
    end
    cpu_inp = 1;
    @(negedge clk);
    idle();
    checks++;
    if (cpu_rdata !== 8'd9 || ski !== 0) begin
      errors++;
      $display("FAIL inp_after: rd=%h ski=%b want 09 0",
               cpu_rdata, ski);
    end
  endtask

  task automatic test_out();
    cpu_sel = 0;
    cpu_wdata = 8'hA5;
    cpu_out = 1;
    @(negedge clk);
    idle();
    checks++;
    if (dev_out_valid[0] !== 1 || dev_out_data[7:0] !== 8'hA5 ||
        sko !== 0 || ovr_err !== 0) begin
      errors++;
      $display("FAIL out: vld=%b d=%h sko=%b ovr=%b want 1 a5 0 0",
               dev_out_valid[0], dev_out_data[7:0], sko, ovr_err);
    end
    cpu_wdata = 8'h3C;
    cpu_out = 1;
    @(negedge clk);
    idle();
    checks++;
    if (ovr_err !== 1 || dev_out_data[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL ovr: ovr=%b d=%h want 1 a5",
               ovr_err, dev_out_data[7:0]);
    end
    @(negedge clk);
    checks++;
    if (ovr_err !== 0) begin
      errors++;
      $display("FAIL ovr_pulse: ovr=%b want 0", ovr_err);
    end
    dev_out_ready = 2'b01;
    @(negedge clk);
    idle();
    checks++;
    if (dev_out_valid[0] !== 0 || sko !== 1) begin
      errors++;
      $display("FAIL out_acc: vld=%b sko=%b want 0 1",
               dev_out_valid[0], sko);
    end
  endtask

  task automatic test_irq();
    cpu_sel = 0; cpu_wdata = 8'h11; cpu_out = 1;
    @(negedge clk);
    idle();
    cpu_sel = 1; cpu_wdata = 8'h22; cpu_out = 1;
    @(negedge clk);
    idle();
    cpu_sel = 0; cpu_ion = 1;
    @(negedge clk);
    idle();
    checks++;
    if (ien !== 1 || dev_out_valid !== 2'b11) begin
      errors++;
      $display("FAIL ion: ien=%b vld=%b want 1 11",
               ien, dev_out_valid);
    end
    @(negedge clk);
    checks++;
    if (irq !== 0) begin
      errors++;
      $display("FAIL irq_idle: irq=%b want 0", irq);
    end
    dev_in_data = {8'h55, 8'h00};
    dev_in_valid = 2'b10;
    @(negedge clk);
    idle();
    checks++;
    if (irq_ch !== 1'b1) begin
      errors++;
      $display("FAIL irq_ch: ch=%b want 1", irq_ch);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1 || irq_ch !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: irq=%b ch=%b want 1 1", irq, irq_ch);
    end
    int_ack = 1;
    @(negedge clk);
    idle();
    checks++;
    if (irq !== 0 || ien !== 0) begin
      errors++;
      $display("FAIL ack: irq=%b ien=%b want 0 0", irq, ien);
    end
    int_ack = 1; cpu_ion = 1;
    @(negedge clk);
    idle();
    checks++;
    if (ien !== 0 || irq !== 0) begin
      errors++;
      $display("FAIL ack_ion: ien=%b irq=%b want 0 0", ien, irq);
    end
    cpu_ion = 1;
    @(negedge clk);
    idle();
    cpu_iof = 1;
    @(negedge clk);
    idle();
    checks++;
    if (ien !== 0 || irq !== 1) begin
      errors++;
      $display("FAIL iof: ien=%b irq=%b want 0 1", ien, irq);
    end
  endtask

  task automatic test_cmd_err();
    cpu_sel = 1; cpu_wdata = 8'hEE;
    cpu_inp = 1; cpu_out = 1;
    @(negedge clk);
    idle();
    checks++;
    if (cmd_err !== 1 || ski !== 1 || sko !== 0 ||
        dev_out_data[15:8] !== 8'h22 || cpu_rdata !== 8'd9 ||
        ovr_err !== 0) begin
      errors++;
      $display("FAIL multi: ce=%b ski=%b sko=%b d=%h rd=%h ovr=%b",
               cmd_err, ski, sko, dev_out_data[15:8], cpu_rdata, ovr_err);
    end
    cpu_ion = 1; cpu_iof = 1;
    @(negedge clk);
    idle();
    checks++;
    if (cmd_err !== 1 || ien !== 0) begin
      errors++;
      $display("FAIL ion_iof: ce=%b ien=%b want 1 0", cmd_err, ien);
    end
    @(negedge clk);
    checks++;
    if (cmd_err !== 0) begin
      errors++;
      $display("FAIL ce_pulse: ce=%b want 0", cmd_err);
    end
    sel3 = 2'd3; wdata3 = 8'hFF; #1;
    checks++;
    if (ski3 !== 0 || sko3 !== 0) begin
      errors++;
      $display("FAIL bad_skip: ski=%b sko=%b want 0 0", ski3, sko3);
    end
    out3 = 1;
    @(negedge clk);
    idle();
    checks++;
    if (cmd3 !== 1 || dev_out_valid3 !== 3'b000 ||
        dev_out_data3 !== '0) begin
      errors++;
      $display("FAIL bad_sel: ce=%b vld=%b d=%h want 1 000 0",
               cmd3, dev_out_valid3, dev_out_data3);
    end
    sel3 = 2'd2; #1;
    checks++;
    if (sko3 !== 1) begin
      errors++;
      $display("FAIL ch2_sko: sko=%b want 1", sko3);
    end
  endtask

  task automatic test_async_reset();
    cpu_sel = 0; cpu_wdata = 8'h5A; cpu_out = 1;
    @(negedge clk);
    idle();
    checks++;
    if (dev_out_valid[0] !== 1 || irq !== 1) begin
      errors++;
      $display("FAIL pre_rst: vld=%b irq=%b want 1 1",
               dev_out_valid[0], irq);
    end
    #2;
    clr = 0;
    dev_in_data = {8'h00, 8'h77};
    dev_in_valid = 2'b01;
    #1;
    checks++;
    if (irq !== 0 || ien !== 0 || dev_out_valid !== 2'b00 ||
        dev_in_ready !== 2'b11 || cpu_rdata !== 0 ||
        dev_out_data !== '0 || ovr_err !== 0 || cmd_err !== 0) begin
      errors++;
      $display("FAIL async_rst: irq=%b ien=%b vld=%b rdy=%b rd=%h d=%h",
               irq, ien, dev_out_valid, dev_in_ready, cpu_rdata,
               dev_out_data);
    end
    repeat (2) @(negedge clk);
    idle();
    clr = 1;
    @(negedge clk);
    checks++;
    if (dev_in_ready !== 2'b11 || ski !== 0 || sko !== 1) begin
      errors++;
      $display("FAIL rst_lost: rdy=%b ski=%b sko=%b want 11 0 1",
               dev_in_ready, ski, sko);
    end
  endtask

  initial begin
    clr = 0;
    cpu_sel = 0; cpu_wdata = '0;
    dev_in_data = '0;
    dev_in_data3 = '0; dev_in_valid3 = '0; dev_out_ready3 = '0;
    sel3 = '0; wdata3 = '0;
    idle();
    test_reset();
    test_inp();
    test_out();
    test_irq();
    test_cmd_err();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
